// File: rtl/pong_pkg.sv
// Shared constants for the pong game-flow controller: FSM encodings, score width,
// serve directions and display geometry defaults.
package pong_pkg;

  localparam int SCORE_W       = 4;
  localparam int TIMER_W       = 9;
  localparam int DEF_DISP_COLS = 800;
  localparam int DEF_DISP_ROWS = 600;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam logic [2:0] ST_ATTRACT = 3'd0;
  localparam logic [2:0] ST_SERVE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_POINT   = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  // Terminal count for a hold of n frames, where the count starts at zero.
  function automatic logic [TIMER_W-1:0] frames_term(input int n);
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame counter: counts frame ticks, clears on request and flags the tick on
// which the programmed terminal count is reached.
module frame_timer
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               tick_i,
  input  logic [TIMER_W-1:0] term_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = tick_i && (count_q == term_i);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: attract/serve/play/point/over sequencing, scoring,
// winner declaration and per-paddle AI/player source select.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int DISP_COLS    = DEF_DISP_COLS,
  parameter int L_GOAL_COL   = 4,
  parameter int R_GOAL_COL   = DISP_COLS - 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               move_up_control_p0,
  input  logic               move_down_control_p0,
  input  logic               move_up_control_p1,
  input  logic               move_down_control_p1,
  input  logic [11:0]        ball_center_col,
  output logic               game_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p0,
  output logic [SCORE_W-1:0] score_p1,
  output logic               winner_valid,
  output logic               winner,
  output logic               ai_sel_p0,
  output logic               ai_sel_p1,
  output logic [2:0]         state
);

  localparam logic [11:0]        L_GOAL = 12'(L_GOAL_COL);
  localparam logic [11:0]        R_GOAL = 12'(R_GOAL_COL);
  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);

  logic [2:0]         state_q, state_d;
  logic               game_run_q, game_run_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic               winner_valid_q, winner_valid_d;
  logic               winner_q, winner_d;
  logic               human0_q, human0_d;
  logic               human1_q, human1_d;
  logic               start_q;

  logic               start_edge, left_goal, right_goal, attract_goal;
  logic               timer_clr, timer_done;
  logic [TIMER_W-1:0] timer_term;

  assign start_edge = start_btn & ~start_q;
  assign left_goal  = ball_center_col <= L_GOAL;
  assign right_goal = ball_center_col >= R_GOAL;

  always_comb begin
    case (state_q)
      ST_SERVE: timer_term = frames_term(SERVE_FRAMES);
      ST_POINT: timer_term = frames_term(POINT_FRAMES);
      ST_OVER:  timer_term = frames_term(OVER_FRAMES);
      default:  timer_term = '0;
    endcase
  end

  // The timer restarts on every state change and idles where no hold is timed.
  assign timer_clr = (state_d != state_q) || (state_q == ST_ATTRACT) || (state_q == ST_PLAY);

  frame_timer u_frame_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .tick_i (frame_tick),
    .term_i (timer_term),
    .done_o (timer_done)
  );

  always_comb begin
    state_d        = state_q;
    serve_dir_d    = serve_dir_q;
    score0_d       = score0_q;
    score1_d       = score1_q;
    winner_valid_d = winner_valid_q;
    winner_d       = winner_q;
    human0_d       = human0_q;
    human1_d       = human1_q;
    attract_goal   = 1'b0;

    case (state_q)
      ST_ATTRACT: begin
        human0_d = human0_q | move_up_control_p0 | move_down_control_p0;
        human1_d = human1_q | move_up_control_p1 | move_down_control_p1;
        if (start_edge) begin
          if (!human0_d && !human1_d) human0_d = 1'b1;
          state_d        = ST_SERVE;
          score0_d       = '0;
          score1_d       = '0;
          winner_valid_d = 1'b0;
          winner_d       = LEFT;
          serve_dir_d    = LEFT;
        end else if (frame_tick && (left_goal || right_goal)) begin
          attract_goal = 1'b1;
          serve_dir_d  = ~serve_dir_q;
        end
      end
      ST_SERVE: begin
        if (timer_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // The conceding side receives the next serve; left wins a double hit.
        if (frame_tick && left_goal) begin
          if (score1_q < WIN) score1_d = score1_q + SCORE_W'(1);
          serve_dir_d = LEFT;
          state_d     = ST_POINT;
        end else if (frame_tick && right_goal) begin
          if (score0_q < WIN) score0_d = score0_q + SCORE_W'(1);
          serve_dir_d = RIGHT;
          state_d     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (timer_done) begin
          if (score0_q == WIN || score1_q == WIN) begin
            state_d        = ST_OVER;
            winner_valid_d = 1'b1;
            winner_d       = (score1_q == WIN) ? RIGHT : LEFT;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (timer_done || start_edge) begin
          state_d  = ST_ATTRACT;
          human0_d = 1'b0;
          human1_d = 1'b0;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase

    game_run_d   = (state_d == ST_ATTRACT) || (state_d == ST_PLAY);
    ball_reset_d = (state_d == ST_SERVE) || (state_d == ST_OVER) || attract_goal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ATTRACT;
      game_run_q     <= 1'b1;
      ball_reset_q   <= 1'b0;
      serve_dir_q    <= LEFT;
      score0_q       <= '0;
      score1_q       <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= LEFT;
      human0_q       <= 1'b0;
      human1_q       <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      game_run_q     <= game_run_d;
      ball_reset_q   <= ball_reset_d;
      serve_dir_q    <= serve_dir_d;
      score0_q       <= score0_d;
      score1_q       <= score1_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
      human0_q       <= human0_d;
      human1_q       <= human1_d;
      start_q        <= start_btn;
    end
  end

  assign state        = state_q;
  assign game_run     = game_run_q;
  assign ball_reset   = ball_reset_q;
  assign serve_dir    = serve_dir_q;
  assign score_p0     = score0_q;
  assign score_p1     = score1_q;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;
  assign ai_sel_p0    = ~human0_q;
  assign ai_sel_p1    = ~human1_q;

endmodule
